// File: rtl/snn_infer_seq_if.sv
// snn_infer_seq_if: tagged-sample output stream from the sequencer to the result FIFO
interface snn_infer_seq_if #(parameter int W = 20);
  logic valid;
  logic ready;
  logic [W-1:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/snn_infer_seq.sv
// snn_infer_seq: per-timestep DAC -> CIM -> ADC scan sequencer pushing tagged samples downstream
module snn_infer_seq #(
  parameter int NUM_OUTPUTS = 10,
  parameter int ADC_W = 8,
  parameter int ADC_MUX_SETTLE_CYCLES = 2,
  parameter int ADC_SAMPLE_CYCLES = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic [7:0] timesteps,
  output logic busy,
  output logic done,
  output logic timeout_err,
  output logic [7:0] ts_idx,
  output logic dac_start,
  input  logic dac_done,
  output logic cim_start,
  input  logic cim_done,
  output logic [3:0] adc_mux_sel,
  output logic adc_sample,
  input  logic [ADC_W-1:0] adc_data,
  snn_infer_seq_if.master out
);
  typedef enum logic [3:0] {
    IDLE, DAC_REQ, DAC_WAIT, CIM_REQ, CIM_WAIT, ADC_SETTLE, ADC_SAMPLE, PUSH, NEXT_TS, DONE
  } state_t;
  state_t state, nxt;
  logic [15:0] wcnt, pcnt;
  logic [3:0] ch, mux_q;
  logic [7:0] cnt;
  logic [ADC_W-1:0] sample;
  logic to, scan, wexp;
  assign scan = state == ADC_SETTLE || state == ADC_SAMPLE;
  assign wexp = {1'b0, wcnt} + 17'd1 >= 17'(TIMEOUT_CYCLES);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign dac_start = state == DAC_REQ;
  assign cim_start = state == CIM_REQ;
  assign adc_sample = state == ADC_SAMPLE;
  assign adc_mux_sel = scan ? ch : mux_q;
  assign out.valid = state == PUSH;
  assign out.data = {ts_idx, ch, sample};
  always_comb begin
    nxt = state;
    to = 1'b0;
    case (state)
      IDLE:       nxt = !start ? IDLE : timesteps == 8'd0 ? DONE : DAC_REQ;
      DAC_REQ:    nxt = DAC_WAIT;
      DAC_WAIT:   begin
        nxt = dac_done ? CIM_REQ : wexp ? IDLE : DAC_WAIT;
        to = !dac_done && wexp;
      end
      CIM_REQ:    nxt = CIM_WAIT;
      CIM_WAIT:   begin
        nxt = cim_done ? ADC_SETTLE : wexp ? IDLE : CIM_WAIT;
        to = !cim_done && wexp;
      end
      ADC_SETTLE: nxt = pcnt == 16'(ADC_MUX_SETTLE_CYCLES - 1) ? ADC_SAMPLE : ADC_SETTLE;
      ADC_SAMPLE: nxt = pcnt == 16'(ADC_SAMPLE_CYCLES - 1) ? PUSH : ADC_SAMPLE;
      PUSH:       nxt = !out.ready ? PUSH : ch == 4'(NUM_OUTPUTS - 1) ? NEXT_TS : ADC_SETTLE;
      NEXT_TS:    nxt = ts_idx == cnt - 8'd1 ? DONE : DAC_REQ;
      DONE:       nxt = IDLE;
      default:    nxt = IDLE;
    endcase
    if (abort) begin
      nxt = IDLE;
      to = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt <= '0;
      pcnt <= '0;
      ch <= '0;
      mux_q <= '0;
      cnt <= '0;
      ts_idx <= '0;
      sample <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      mux_q <= adc_mux_sel;
      wcnt <= (state == DAC_WAIT || state == CIM_WAIT) ? (&wcnt ? wcnt : wcnt + 16'd1) : '0;
      pcnt <= (scan && nxt == state) ? pcnt + 16'd1 : '0;
      if (to) timeout_err <= 1'b1;
      if (state == IDLE && nxt != IDLE) begin
        cnt <= timesteps;
        ts_idx <= '0;
        timeout_err <= 1'b0;
      end
      if (state == CIM_WAIT && nxt == ADC_SETTLE) ch <= '0;
      if (state == PUSH && nxt == ADC_SETTLE) ch <= ch + 4'd1;
      if (state == ADC_SAMPLE && nxt == PUSH) sample <= adc_data;
      if (state == NEXT_TS && nxt == DAC_REQ) ts_idx <= ts_idx + 8'd1;
    end
  end
endmodule

// File: doc/snn_infer_seq.md
Name: snn_infer_seq

Overview:
- Inference sequencer for the SNN analog datapath. For each timestep it pulses the DAC, waits for it, pulses the CIM array, waits for it, then scans all NUM_OUTPUTS ADC channels through the mux and captures one sample per channel.
- Each sample is pushed, with backpressure, into the output FIFO as a tagged word.
- Sits between the control register block (start/abort/timesteps) and the DAC/CIM/ADC behavioural models.

Parameters:
- NUM_OUTPUTS, 10, ADC channels scanned per timestep (1..16).
- ADC_W, 8, ADC sample width.
- ADC_MUX_SETTLE_CYCLES, 2, cycles mux_sel is held before sampling (>=1).
- ADC_SAMPLE_CYCLES, 3, cycles adc_sample is held high (>=1).
- TIMEOUT_CYCLES, 255, maximum wait for dac_done/cim_done (>=1, <=65535).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin inference; honoured only in IDLE
- abort  in  1  cancel inference; effective in any state
- timesteps  in  8  timestep count, latched on accepted start (default config 20)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion
- timeout_err  out  1  sticky; set on wait timeout, cleared on accepted start or rst
- ts_idx  out  8  current timestep, 0-based
- dac_start  out  1  one-cycle pulse
- dac_done  in  1  DAC completion pulse
- cim_start  out  1  one-cycle pulse
- cim_done  in  1  CIM completion pulse
- adc_mux_sel  out  4  selected channel
- adc_sample  out  1  ADC sample strobe
- adc_data  in  ADC_W  ADC result; valid on the last adc_sample cycle
- out_valid  out  1  output word valid
- out_ready  in  1  FIFO can accept
- out_data  out  12+ADC_W  {ts_idx[7:0], ch[3:0], sample[ADC_W-1:0]}

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset has priority over every other input. Asserting rst mid-operation returns to IDLE on the next edge and drops all strobes.
- States: IDLE, DAC_REQ, DAC_WAIT, CIM_REQ, CIM_WAIT, ADC_SETTLE, ADC_SAMPLE, PUSH, NEXT_TS, DONE.
- IDLE:
  - On start: latch timesteps, clear timeout_err and ts_idx.
  - If timesteps==0, go to DONE (done pulses 1 cycle after start, no datapath activity).
  - Otherwise go to DAC_REQ.
- DAC_REQ: dac_start=1 for exactly 1 cycle, then DAC_WAIT. Wait counter cleared.
- DAC_WAIT:
  - dac_done -> CIM_REQ.
  - Else the counter increments; when it reaches TIMEOUT_CYCLES, set timeout_err and go to IDLE with no done pulse.
  - dac_done on the same cycle the counter reaches TIMEOUT_CYCLES counts as success.
- CIM_REQ / CIM_WAIT: identical rules using cim_start and cim_done. On cim_done, set ch=0 and go to ADC_SETTLE.
- ADC_SETTLE: adc_mux_sel=ch for ADC_MUX_SETTLE_CYCLES cycles, then ADC_SAMPLE.
- ADC_SAMPLE:
  - adc_mux_sel holds; adc_sample=1 for ADC_SAMPLE_CYCLES cycles.
  - adc_data is registered on the last sample cycle. Go to PUSH.
- PUSH:
  - out_valid=1 with out_data stable until the out_ready handshake.
  - On handshake: if ch==NUM_OUTPUTS-1 go to NEXT_TS, else ch++ and go to ADC_SETTLE.
  - With out_ready held high, out_valid is high for exactly 1 cycle.
- NEXT_TS: if ts_idx==latched count-1 go to DONE, else ts_idx++ and go to DAC_REQ.
- DONE: done=1 for 1 cycle, then IDLE. busy is still high in DONE.
- Per-channel cost with out_ready=1: SETTLE + SAMPLE + 1 cycles (6 at defaults).
- adc_mux_sel holds its last value when not scanning. It is 0 after reset.
- abort:
  - Next state is IDLE; every strobe and out_valid is low from that edge. No done pulse.
  - timeout_err is unchanged.
  - A word presented in PUSH is dropped.
- start while busy is ignored. start and abort together in IDLE: abort wins and the state stays IDLE.
- dac_done/cim_done outside their WAIT states are ignored.
- Counters: the ts_idx increment is bounded by the latched count, so no wrap. The wait counter is 16 bits and saturates.

Test Plan:
- Nominal:
  - Stimulus: timesteps=2, dac_done 5 cycles after dac_start, cim_done 10 cycles after cim_start, out_ready=1, adc_data=ch+0x10.
  - Response: 20 words {ts,ch,0x10+ch} in order; 2 dac_start and 2 cim_start pulses; done exactly once; busy low the cycle after done.
- Backpressure:
  - Stimulus: out_ready low for 7 cycles during ts0 ch3.
  - Response: out_valid and out_data held constant for all 7 cycles; adc_sample stays low; the next adc_sample starts 2 cycles after the handshake.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=255, cim_done never asserted.
  - Response: timeout_err rises, busy falls, no done and no output words.
  - Follow-up: the next start clears timeout_err.
- Zero and edge counts:
  - Stimulus: timesteps=0.
  - Response: done one cycle after start, no dac_start.
  - Stimulus: timesteps=255.
  - Response: 2550 words; final ts_idx=254.
- Abort and reset mid-scan:
  - Stimulus: abort while in ADC_SAMPLE at ts1 ch5.
  - Response: strobes low next cycle, no done.
  - Stimulus: rst during PUSH.
  - Response: all outputs 0 next cycle.
- Ignored inputs:
  - Stimulus: start pulsed while busy; spurious dac_done while in CIM_WAIT.
  - Response: sequence and output word count unchanged.
